// File: rtl/answer_ctrl.sv
// Quiz-show answer controller: buzz-in arbitration, per-question countdown and
// saturating per-player scoring for up to four players.
module answer_ctrl #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       is_set_over,
    input  logic [5:0] num_people,
    input  logic [5:0] count_seconds,
    input  logic [5:0] correct_point,
    input  logic [5:0] mistake_point,
    input  logic       start_btn,
    input  logic       judge_ok,
    input  logic       judge_bad,
    input  logic [3:0] player_btn,
    output logic [2:0] state,
    output logic [1:0] winner,
    output logic       winner_valid,
    output logic [5:0] remaining,
    output logic [7:0] score0,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [7:0] score3,
    output logic       alarm
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READY  = 3'd1;
    localparam logic [2:0] ST_OPEN   = 3'd2;
    localparam logic [2:0] ST_ANSWER = 3'd3;

    localparam int unsigned NPLAYER = 4;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned PT_W    = 6;
    localparam int unsigned CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [2:0]         state_q, state_d;
    logic [1:0]         winner_q, winner_d;
    logic               wv_q, wv_d;
    logic [PT_W-1:0]    rem_q, rem_d;
    logic [SCORE_W-1:0] score_q [NPLAYER];
    logic [SCORE_W-1:0] score_d [NPLAYER];
    logic               alarm_q, alarm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               start_prev, ok_prev, bad_prev;
    logic [NPLAYER-1:0] player_prev;

    logic               start_ev, ok_ev, bad_ev;
    logic [NPLAYER-1:0] player_ev;
    logic [NPLAYER-1:0] enable_mask;
    logic [NPLAYER-1:0] buzz;
    logic               buzz_any;
    logic [1:0]         buzz_idx;
    logic               tick;
    logic               rem_expire;
    logic               rem_dec;

    // Adds points, clamping at the top of the score range.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [PT_W-1:0]    p);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + (SCORE_W+1)'(p);
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    // Removes points, clamping at zero.
    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] s,
                                                   input logic [PT_W-1:0]    p);
        logic [SCORE_W-1:0] pw;
        pw = SCORE_W'(p);
        return (s < pw) ? '0 : (s - pw);
    endfunction

    assign start_ev  = start_btn & ~start_prev;
    assign ok_ev     = judge_ok & ~ok_prev;
    assign bad_ev    = judge_bad & ~bad_prev;
    assign player_ev = player_btn & ~player_prev;

    // Player count clamped to 2..4 before masking buzzers.
    always_comb begin
        enable_mask = 4'b1111;
        if (num_people < 6'd3) begin
            enable_mask = 4'b0011;
        end else if (num_people == 6'd3) begin
            enable_mask = 4'b0111;
        end
    end

    assign buzz     = player_ev & enable_mask;
    assign buzz_any = |buzz;

    // Lowest index wins a same-cycle tie.
    always_comb begin
        buzz_idx = 2'd0;
        for (int i = NPLAYER - 1; i >= 0; i--) begin
            if (buzz[i]) begin
                buzz_idx = 2'(i);
            end
        end
    end

    assign tick       = (cnt_q == CNT_W'(CLK_HZ - 1));
    assign rem_expire = tick && (rem_q == 6'd1);
    assign rem_dec    = tick && (rem_q != 6'd0);

    always_comb begin
        state_d = state_q;
        winner_d = winner_q;
        wv_d = wv_q;
        rem_d = rem_q;
        score_d = score_q;
        alarm_d = 1'b0;
        cnt_d = tick ? '0 : (cnt_q + CNT_W'(1));

        if (!is_set_over) begin
            state_d = ST_IDLE;
            wv_d = 1'b0;
            rem_d = '0;
            for (int i = 0; i < NPLAYER; i++) begin
                score_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_READY;
                end
                ST_READY: begin
                    if (start_ev) begin
                        state_d = ST_OPEN;
                        rem_d = count_seconds;
                        cnt_d = '0;
                        wv_d = 1'b0;
                    end
                end
                ST_OPEN: begin
                    // A buzz beats a countdown expiring on the same edge.
                    if (buzz_any) begin
                        state_d = ST_ANSWER;
                        winner_d = buzz_idx;
                        wv_d = 1'b1;
                        rem_d = count_seconds;
                        cnt_d = '0;
                    end else if (rem_expire) begin
                        state_d = ST_READY;
                        rem_d = '0;
                        alarm_d = 1'b1;
                        wv_d = 1'b0;
                    end else if (rem_dec) begin
                        rem_d = rem_q - 6'd1;
                    end
                end
                ST_ANSWER: begin
                    if (bad_ev) begin
                        state_d = ST_READY;
                        score_d[winner_q] = sat_sub(score_q[winner_q], mistake_point);
                    end else if (ok_ev) begin
                        state_d = ST_READY;
                        score_d[winner_q] = sat_add(score_q[winner_q], correct_point);
                    end else if (rem_expire) begin
                        state_d = ST_READY;
                        rem_d = '0;
                        alarm_d = 1'b1;
                        score_d[winner_q] = sat_sub(score_q[winner_q], mistake_point);
                    end else if (rem_dec) begin
                        rem_d = rem_q - 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            winner_q <= '0;
            wv_q <= 1'b0;
            rem_q <= '0;
            alarm_q <= 1'b0;
            cnt_q <= '0;
            for (int i = 0; i < NPLAYER; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            winner_q <= winner_d;
            wv_q <= wv_d;
            rem_q <= rem_d;
            alarm_q <= alarm_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < NPLAYER; i++) begin
                score_q[i] <= score_d[i];
            end
        end
    end

    // Previous-sample registers for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b0;
            ok_prev <= 1'b0;
            bad_prev <= 1'b0;
            player_prev <= '0;
        end else begin
            start_prev <= start_btn;
            ok_prev <= judge_ok;
            bad_prev <= judge_bad;
            player_prev <= player_btn;
        end
    end

    assign state        = state_q;
    assign winner       = winner_q;
    assign winner_valid = wv_q;
    assign remaining    = rem_q;
    assign score0       = score_q[0];
    assign score1       = score_q[1];
    assign score2       = score_q[2];
    assign score3       = score_q[3];
    assign alarm        = alarm_q;

endmodule
